regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb_if.sv | 28 ++
 rtl/regfile_wb.sv | 89 ++++++++
 tb/tb_regfile_wb.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Register-file bus: two combinational read ports, one valid/ready writeback
// port carrying ALU result and flags, plus flag/overflow status outputs.
interface regfile_wb_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_overflow;
  logic        wb_zero;
  logic        wb_equal;
  logic [2:0]  flags;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  modport slave (
    input  ra1, ra2, wb_valid, wb_addr, wb_data, wb_overflow, wb_zero, wb_equal,
    output rd1, rd2, wb_ready, flags, ovf_sticky, ovf_count
  );

  modport master (
    output ra1, ra2, wb_valid, wb_addr, wb_data, wb_overflow, wb_zero, wb_equal,
    input  rd1, rd2, wb_ready, flags, ovf_sticky, ovf_count
  );
endinterface

// File: rtl/regfile_wb.sv
// 32x32 register file with ALU writeback port, write-through bypass, flag capture
// and saturating overflow counter. A CLEAR sweep zeroes r1..r31 after every reset.
module regfile_wb (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_idx;
  logic [4:0]  w_idx_next;
  logic [31:0] r_mem [32];
  logic [2:0]  r_flags;
  logic        r_ovf_sticky;
  logic [7:0]  r_ovf_count;
  logic        w_ready;
  logic        w_accept;
  logic        w_read_en;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_ready      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_idx_next = r_idx + 5'd1;
        if (r_idx == 5'd31) begin
          w_state_next = RUN;
          w_idx_next   = 5'd1;
        end
      end
      RUN:     w_ready = ~rst;
      default: w_state_next = CLEAR;
    endcase
  end

  assign w_accept  = bus.wb_valid & w_ready;
  assign w_read_en = (r_state == RUN) & ~rst;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= 5'd1;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags      <= 3'b000;
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= 8'd0;
    end else if (w_accept) begin
      r_flags <= {bus.wb_overflow, bus.wb_zero, bus.wb_equal};
      if (bus.wb_overflow) begin
        r_ovf_sticky <= 1'b1;
        if (r_ovf_count != 8'hFF) r_ovf_count <= r_ovf_count + 8'd1;
      end
    end
  end

  // NOTE: the array has no reset branch; the CLEAR sweep zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR && !rst) begin
      r_mem[r_idx] <= 32'd0;
    end else if (w_accept && bus.wb_addr != 5'd0) begin
      r_mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Entry 0 is never read; the bypass forwards an accepted write in the same cycle.
  assign bus.rd1 = (!w_read_en || bus.ra1 == 5'd0) ? 32'd0 :
                   (w_accept && bus.wb_addr == bus.ra1) ? bus.wb_data : r_mem[bus.ra1];
  assign bus.rd2 = (!w_read_en || bus.ra2 == 5'd0) ? 32'd0 :
                   (w_accept && bus.wb_addr == bus.ra2) ? bus.wb_data : r_mem[bus.ra2];

  assign bus.wb_ready   = w_ready;
  assign bus.flags      = r_flags;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus random traffic,
// compared against a cycle-level behavioural model of the register file.
module tb_regfile_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_if bus ();

  regfile_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: register contents, cycles of clearing left, status.
  logic [31:0] m_mem [32];
  int          m_clear_left = 31;
  logic [2:0]  m_flags = 3'b000;
  logic        m_sticky = 1'b0;
  int          m_count = 0;

  function automatic logic m_ready();
    return !rst && (m_clear_left == 0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] ra);
    if (!m_ready() || ra == 5'd0) return 32'd0;
    if (bus.wb_valid && bus.wb_addr == ra) return bus.wb_data;
    return m_mem[ra];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, ".wb_ready"},   {31'd0, bus.wb_ready},   {31'd0, m_ready()});
    check({tag, ".rd1"},        bus.rd1,                 m_rd(bus.ra1));
    check({tag, ".rd2"},        bus.rd2,                 m_rd(bus.ra2));
    check({tag, ".flags"},      {29'd0, bus.flags},      {29'd0, m_flags});
    check({tag, ".ovf_sticky"}, {31'd0, bus.ovf_sticky}, {31'd0, m_sticky});
    check({tag, ".ovf_count"},  {24'd0, bus.ovf_count},  m_count);
  endtask

  // Advance the model by one edge using the inputs as currently driven, then clock the DUT.
  task automatic step();
    if (rst) begin
      m_clear_left = 31;
      m_flags      = 3'b000;
      m_sticky     = 1'b0;
      m_count      = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (bus.wb_valid) begin
      if (bus.wb_addr != 5'd0) m_mem[bus.wb_addr] = bus.wb_data;
      m_flags = {bus.wb_overflow, bus.wb_zero, bus.wb_equal};
      if (bus.wb_overflow) begin
        m_sticky = 1'b1;
        if (m_count < 255) m_count++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic [4:0] r1, input logic [4:0] r2);
    bus.wb_valid    = v;
    bus.wb_addr     = a;
    bus.wb_data     = d;
    {bus.wb_overflow, bus.wb_zero, bus.wb_equal} = f;
    bus.ra1         = r1;
    bus.ra2         = r2;
  endtask

  task automatic drive_random(input logic force_valid, input logic ovf_bit, input logic use_ovf);
    logic [4:0] a;
    logic [2:0] f;
    a = 5'($urandom_range(0, 31));
    f = 3'($urandom);
    if (use_ovf) f[2] = ovf_bit;
    drive(force_valid | 1'($urandom), a, $urandom, f,
          ($urandom_range(0, 3) == 0) ? a : 5'($urandom),
          ($urandom_range(0, 3) == 0) ? a : 5'($urandom));
  endtask

  // Run the clear sweep with random reads and optional held writeback.
  task automatic run_clear(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.ra1 = 5'($urandom);
      bus.ra2 = 5'($urandom);
      check_all(tag);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd0, 5'd0);

    // Reset state, then exactly 31 cycles not ready, then ready.
    rst = 1'b1;
    step();
    step();
    check("reset.ready", {31'd0, bus.wb_ready}, 32'd0);
    check_all("reset");
    rst = 1'b0;
    run_clear("clear", 31);
    check("ready_after_clear", {31'd0, bus.wb_ready}, 32'd1);

    // All 32 registers read zero after the sweep.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 3'b000, 5'(i), 5'(31 - i));
      check_all("read_zero");
      check("read_zero.rd1", bus.rd1, 32'd0);
    end

    // Bypass on write to r5, then registered value next cycle.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 3'b000, 5'd5, 5'd5);
    check_all("bypass");
    check("bypass.rd1", bus.rd1, 32'hDEADBEEF);
    step();
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd5, 5'd5);
    check_all("after_write");
    check("after_write.rd1", bus.rd1, 32'hDEADBEEF);

    // Write to r0: no storage, flags still captured.
    drive(1'b1, 5'd0, 32'h12345678, 3'b010, 5'd0, 5'd0);
    check_all("r0_write");
    check("r0_write.rd1", bus.rd1, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd0, 5'd5);
    check_all("r0_after");
    check("r0_after.flags", {29'd0, bus.flags}, 32'h2);

    // Overflow counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive_random(1'b1, 1'b1, 1'b1);
      check_all("ovf_run");
      step();
    end
    check("ovf_sat.count", {24'd0, bus.ovf_count}, 32'd255);
    check("ovf_sat.sticky", {31'd0, bus.ovf_sticky}, 32'd1);
    drive(1'b1, 5'd9, 32'h0000_0042, 3'b001, 5'd9, 5'd1);
    check_all("ovf_clear_op");
    step();
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd9, 5'd1);
    check_all("ovf_after");
    check("ovf_after.flag2", {31'd0, bus.flags[2]}, 32'd0);
    check("ovf_after.sticky", {31'd0, bus.ovf_sticky}, 32'd1);
    check("ovf_after.count", {24'd0, bus.ovf_count}, 32'd255);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random(1'b0, 1'b0, 1'b0);
      check_all("random");
      step();
    end

    // Reset overrides a concurrent writeback and wipes r7.
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 3'b100, 5'd7, 5'd8);
    check_all("pre_rst_write");
    step();
    rst = 1'b1;
    drive(1'b1, 5'd8, 32'h5555AAAA, 3'b100, 5'd7, 5'd8);
    check_all("in_reset");
    check("in_reset.rd1", bus.rd1, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd7, 5'd8);
    run_clear("reclear", 31);
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd7, 5'd8);
    check_all("post_rst");
    check("post_rst.r7", bus.rd1, 32'd0);
    check("post_rst.r8", bus.rd2, 32'd0);
    check("post_rst.count", {24'd0, bus.ovf_count}, 32'd0);

    // Reset mid-clear restarts the full sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_clear("partial_clear", 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_clear("restart_clear", 31);
    check("restart.ready", {31'd0, bus.wb_ready}, 32'd1);

    // Writeback held through CLEAR is taken on the first RUN cycle.
    drive(1'b1, 5'd3, 32'h0000_0077, 3'b000, 5'd3, 5'd3);
    step();
    check_all("pre_hold");
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h0000_0001, 3'b101, 5'd3, 5'd4);
    for (int i = 0; i < 31; i++) begin
      check_all("hold_clear");
      step();
    end
    check_all("hold_first_run");
    check("hold_first_run.ready", {31'd0, bus.wb_ready}, 32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0, 3'b000, 5'd3, 5'd4);
    check_all("hold_after");
    check("hold_after.r3", bus.rd1, 32'd1);
    check("hold_after.flags", {29'd0, bus.flags}, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
